// File: rtl/fifo_port_arbiter.sv
// Controller for a shared single-clock FIFO memory macro: sequences its reset,
// round-robin arbitrates two writers onto the write port and gates reads by occupancy.
module fifo_port_arbiter #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic                  mem_rst,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  last_grant
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    last_grant_q, last_grant_d;
    logic                    rr_q, rr_d;
    logic                    run, full_w, empty_w, grant0, grant1, wr_acc, rd_acc;

    always_comb begin
        full_w  = (count_q == ADDR_WIDTH'(DEPTH));
        empty_w = (count_q == '0);
        // A flush request in RUN pre-empts every handshake in the same cycle.
        run     = (state_q == ST_RUN) && !flush;
        grant0  = run && !full_w && req0_valid && (!req1_valid || !rr_q);
        grant1  = run && !full_w && req1_valid && (!req0_valid || rr_q);
        wr_acc  = grant0 || grant1;
        rd_acc  = run && rd_req && !empty_w;

        state_d      = state_q;
        count_d      = count_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        rr_d         = rr_q;
        wr_en_d      = wr_acc;
        rd_en_d      = rd_acc;
        // Kills a read already in flight when the flush is seen.
        rd_valid_d   = rd_en_q && run;

        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    if (wr_acc) begin
                        rr_d         = grant0;
                        last_grant_d = grant1;
                        wr_data_d    = grant1 ? req1_data : req0_data;
                    end
                    case ({wr_acc, rd_acc})
                        2'b10:   count_d = count_q + ADDR_WIDTH'(1);
                        2'b01:   count_d = count_q - ADDR_WIDTH'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                count_d = '0;
            end
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            count_q      <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            last_grant_q <= 1'b0;
            rr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            rd_valid_q   <= rd_valid_d;
            last_grant_q <= last_grant_d;
            rr_q         <= rr_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rd_ack      = rd_acc;
    assign rd_valid    = rd_valid_q;
    assign mem_rst     = (state_q != ST_RUN);
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign mem_rd_en   = rd_en_q;
    assign count       = count_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a small behavioural memory macro model.
module tb_fifo_port_arbiter;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          rd_req = 1'b0;
    logic          rd_ack, rd_valid, mem_rst, mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_wr_data;
    logic [AW-1:0] count;
    logic          full, empty, last_grant;

    int checks = 0;
    int errors = 0;

    // Memory macro model: registered read, pointers cleared by mem_rst.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (mem_wr_en) begin
                mem[wp[3:0]] <= mem_wr_data;
                wp <= wp + 1'b1;
            end
            if (mem_rd_en) begin
                rd_data <= mem[rp[3:0]];
                rp <= rp + 1'b1;
            end
        end
    end

    fifo_port_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .mem_rst(mem_rst),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
        .count(count), .full(full), .empty(empty), .last_grant(last_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        flush = 0; req0_valid = 0; req1_valid = 0; rd_req = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks += 4;
        if (mem_rst !== 1'b1) begin errors++; $display("FAIL rst_mem_rst: got %b want 1", mem_rst); end
        if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_enables: got %b%b%b want 000", mem_wr_en, mem_rd_en, rd_valid);
        end
        if (last_grant !== 1'b0 || mem_wr_data !== 8'h00) begin
            errors++; $display("FAIL rst_grant_data: got %b/%h want 0/00", last_grant, mem_wr_data);
        end
        tick();
        rst_n = 1; req0_valid = 1; req0_data = 8'h77;
        #1;
        checks += 2;
        if (mem_rst !== 1'b1) begin errors++; $display("FAIL init_mem_rst: got %b want 1", mem_rst); end
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL init_ready: got %b want 0", req0_ready); end
        req0_valid = 0;
        tick();
        req0_valid = 1;
        #1;
        checks += 4;
        if (mem_rst !== 1'b0) begin errors++; $display("FAIL run_mem_rst: got %b want 0", mem_rst); end
        if (empty !== 1'b1) begin errors++; $display("FAIL run_empty: got %b want 1", empty); end
        if (count !== 5'd0) begin errors++; $display("FAIL run_count: got %0d want 0", count); end
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %b want 1", req0_ready); end
        req0_valid = 0;
        #1;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] wdat [2];
        wdat[0] = 8'hA1; wdat[1] = 8'hA2;
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; req0_data = wdat[i];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready%0d: got %b want 1", i, req0_ready); end
            tick();
            checks += 2;
            if (mem_wr_en !== 1'b1 || mem_wr_data !== wdat[i]) begin
                errors++; $display("FAIL wr_data%0d: got %b/%h want 1/%h", i, mem_wr_en, mem_wr_data, wdat[i]);
            end
            if (count !== AW'(i + 1)) begin errors++; $display("FAIL wr_count%0d: got %0d want %0d", i, count, i + 1); end
        end
        req0_valid = 0;
        rd_req = 1;
        #1;
        checks++;
        if (rd_ack !== 1'b1) begin errors++; $display("FAIL rd_ack0: got %b want 1", rd_ack); end
        tick();
        checks += 3;
        if (rd_ack !== 1'b1) begin errors++; $display("FAIL rd_ack1: got %b want 1", rd_ack); end
        if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL rd_en1: got %b want 1", mem_rd_en); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_early: got %b want 0", rd_valid); end
        tick();
        checks += 3;
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL rd_ack2_empty: got %b want 0", rd_ack); end
        if (count !== 5'd0) begin errors++; $display("FAIL rd_count: got %0d want 0", count); end
        if (rd_valid !== 1'b1 || rd_data !== 8'hA1) begin
            errors++; $display("FAIL rd_data0: got %b/%h want 1/a1", rd_valid, rd_data);
        end
        rd_req = 0;
        tick();
        checks += 2;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA2) begin
            errors++; $display("FAIL rd_data1: got %b/%h want 1/a2", rd_valid, rd_data);
        end
        if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rd_en_third: got %b want 0", mem_rd_en); end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_end: got %b want 0", rd_valid); end
    endtask

    task automatic test_alternate();
        logic g;
        do_reset();
        req0_valid = 1; req0_data = 8'h10;
        req1_valid = 1; req1_data = 8'h20;
        for (int i = 0; i < DEPTH; i++) begin
            g = i[0];
            #1;
            checks++;
            if (req0_ready !== ~g || req1_ready !== g) begin
                errors++; $display("FAIL alt_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, ~g, g);
            end
            tick();
            checks += 2;
            if (mem_wr_en !== 1'b1 || mem_wr_data !== (g ? 8'h20 : 8'h10) || last_grant !== g) begin
                errors++; $display("FAIL alt_wr%0d: got %b/%h/%b want 1/%h/%b", i, mem_wr_en, mem_wr_data, last_grant, g ? 8'h20 : 8'h10, g);
            end
            if (count !== AW'(i + 1)) begin errors++; $display("FAIL alt_count%0d: got %0d want %0d", i, count, i + 1); end
        end
        #1;
        checks += 2;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL alt_full_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL alt_full: got %b/%0d want 1/16", full, count); end
        req1_valid = 0;
        tick();
        checks++;
        if (mem_wr_en !== 1'b0 || count !== 5'd16) begin
            errors++; $display("FAIL full_hold: got %b/%0d want 0/16", mem_wr_en, count);
        end
    endtask

    task automatic test_full_rw();
        req0_valid = 1; req0_data = 8'h33; rd_req = 1;
        #1;
        checks += 2;
        if (rd_ack !== 1'b1) begin errors++; $display("FAIL full_rd_ack: got %b want 1", rd_ack); end
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL full_wr_refused: got %b want 0", req0_ready); end
        tick();
        rd_req = 0;
        #1;
        checks += 2;
        if (count !== 5'd15 || full !== 1'b0) begin errors++; $display("FAIL full_after_rd: got %0d/%b want 15/0", count, full); end
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL full_wr_retry: got %b want 1", req0_ready); end
        tick();
        req0_valid = 0;
        checks++;
        if (count !== 5'd16 || mem_wr_data !== 8'h33 || mem_wr_en !== 1'b1) begin
            errors++; $display("FAIL full_refill: got %0d/%h/%b want 16/33/1", count, mem_wr_data, mem_wr_en);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 8'h50 + DW'(i);
            tick();
        end
        req0_valid = 0; rd_req = 1;
        tick();
        checks++;
        if (count !== 5'd4 || mem_rd_en !== 1'b1) begin
            errors++; $display("FAIL fl_pre: got %0d/%b want 4/1", count, mem_rd_en);
        end
        flush = 1; req1_valid = 1; req1_data = 8'hEE;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || rd_ack !== 1'b0 || mem_rst !== 1'b0) begin
            errors++; $display("FAIL fl_req_cycle: got %b%b%b want 000", req1_ready, rd_ack, mem_rst);
        end
        tick();
        checks += 2;
        if (mem_rst !== 1'b1 || req1_ready !== 1'b0 || rd_ack !== 1'b0) begin
            errors++; $display("FAIL fl_state: got %b%b%b want 100", mem_rst, req1_ready, rd_ack);
        end
        if (rd_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL fl_kill: got %b%b%b want 000", rd_valid, mem_rd_en, mem_wr_en);
        end
        flush = 0; req1_valid = 0; rd_req = 0;
        tick();
        checks += 2;
        if (mem_rst !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL fl_after: got %b/%b want 0/0", mem_rst, rd_valid);
        end
        if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL fl_count: got %0d/%b want 0/1", count, empty); end
    endtask

    task automatic test_async_reset();
        req0_valid = 1; req0_data = 8'h61;
        req1_valid = 1; req1_data = 8'h62;
        tick(); tick(); tick();
        #2;
        rst_n = 0;
        #1;
        checks += 2;
        if (mem_rst !== 1'b1 || mem_wr_en !== 1'b0 || count !== 5'd0 || last_grant !== 1'b0) begin
            errors++; $display("FAIL ar_clear: got %b/%b/%0d/%b want 1/0/0/0", mem_rst, mem_wr_en, count, last_grant);
        end
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL ar_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        rst_n = 1;
        #1;
        checks++;
        if (mem_rst !== 1'b1) begin errors++; $display("FAIL ar_init: got %b want 1", mem_rst); end
        tick();
        checks++;
        if (mem_rst !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL ar_run: got %b/%b/%0d want 0/1/0", mem_rst, empty, count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_full_rw();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Single-clock controller that sequences the shared FIFO memory macro: it holds the memory in synchronous reset, arbitrates two write requesters onto the single write port, and gates read requests.
- Tracks occupancy so the memory's free-running address counters never overrun or underrun.
- Sits between client logic and the memory instance. The memory runs with wr_clk = rd_clk = clk, and its active-high synchronous reset is driven from this block's mem_rst.

Parameters:
- DEPTH, 16, memory depth in words; power of 2, at least 2.
- DATA_WIDTH, 8, data word width.
- ADDR_WIDTH, $clog2(DEPTH)+1, occupancy counter width; matches the memory pointer width.

Ports:
- clk, in, 1, single clock for controller and memory.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, request to empty the FIFO.
- req0_valid, in, 1, requester 0 has a write word.
- req0_data, in, DATA_WIDTH, requester 0 write data.
- req0_ready, out, 1, requester 0 word accepted this cycle.
- req1_valid, in, 1, requester 1 has a write word.
- req1_data, in, DATA_WIDTH, requester 1 write data.
- req1_ready, out, 1, requester 1 word accepted this cycle.
- rd_req, in, 1, consumer read request.
- rd_ack, out, 1, read request accepted this cycle.
- rd_valid, out, 1, memory rd_data valid this cycle.
- mem_rst, out, 1, active-high synchronous reset to the memory.
- mem_wr_en, out, 1, memory write enable.
- mem_wr_data, out, DATA_WIDTH, memory write data.
- mem_rd_en, out, 1, memory read enable.
- count, out, ADDR_WIDTH, words stored (0..DEPTH).
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- last_grant, out, 1, ID of the last accepted writer.

Behaviour:
- Async reset (rst_n low):
  - state = INIT, count = 0.
  - mem_rst = 1.
  - mem_wr_en, mem_rd_en, rd_valid, mem_wr_data, last_grant = 0.
  - The round-robin pointer favours requester 0.
- FSM states INIT, RUN, FLUSH:
  - INIT: mem_rst = 1 for exactly 1 cycle after reset release, then go to RUN.
  - RUN: normal operation. If flush = 1, go to FLUSH (flush has priority over any handshake that cycle; no ready/ack is asserted).
  - FLUSH: mem_rst = 1 for 1 cycle, count <= 0, then go to RUN. A flush asserted during FLUSH is ignored.
  - A flush during RUN requires mem_wr_en/mem_rd_en already in flight to be killed: both are forced to 0 on the FLUSH cycle, and rd_valid is forced to 0 on the FLUSH cycle and the following cycle.
  - In INIT and FLUSH all ready and rd_ack outputs are 0.
- Write arbitration (combinational, RUN only, !full):
  - One valid requester: it is granted.
  - Both valid: grant the one favoured by the round-robin pointer.
  - The pointer flips to favour the non-granted requester only when a grant occurs.
  - The granted reqN_ready = 1; the other is 0. ready never depends on its own requester's data.
  - Accepted word: next cycle mem_wr_en = 1 and mem_wr_data = the accepted data (1-cycle latency); last_grant is updated to the granted requester.
- Read (RUN only):
  - rd_ack = rd_req & !empty (combinational).
  - On accept: mem_rd_en = 1 next cycle, then rd_valid = 1 the cycle after that (2 cycles from rd_ack to valid data).
- Occupancy, registered:
  - Write accept alone: +1.
  - Read accept alone: -1.
  - Both accepted: unchanged.
  - full and empty are decoded from the current registered count. A write is refused when full even if a read is accepted the same cycle. A read is refused when empty even if a write is accepted the same cycle.
  - count never leaves 0..DEPTH; the memory pointers wrap naturally modulo 2^ADDR_WIDTH.
- Async reset mid-operation aborts everything immediately and re-enters INIT.

Test Plan:
- Reset release → mem_rst high exactly 1 cycle, then state RUN; empty = 1, count = 0, req0_ready/req1_ready respond the cycle after INIT.
- req0 writes 0xA1, 0xA2, then 3 rd_req pulses → rd_valid on 2 cycles with data 0xA1, 0xA2; third rd_ack = 0; count returns to 0.
- req0 and req1 held valid continuously with data 0x10/0x20 → grants alternate 0, 1, 0, 1…; memory receives 0x10, 0x20, 0x10, …; ready drops when count = 16, full = 1.
- At full, same-cycle rd_req and req0_valid → rd_ack = 1, req0_ready = 0, count = 15; next cycle the write is accepted and count = 16.
- Fill 5 words, then assert flush together with req1_valid and rd_req → no ready/ack, mem_rst pulses 1 cycle, count = 0, empty = 1, no rd_valid.
- Assert rst_n low mid-burst → outputs clear asynchronously; after release, INIT mem_rst pulse occurs and the FIFO is empty.
